button_count_controller: RTL and testbench

Sequencing controller that lets a user drive one shared WIDTH-bit count register from three pushbuttons: UP, DOWN and CLEAR.
- It performs per-button single-pulse edge detection and fixed-priority arbitration when presses coincide.
- It provides hold-to-auto-repeat for UP/DOWN, with wrap or saturate arithmetic.
- It sits between the board's synchronised, debounced button levels and the LED/7-segment display logic that consumes OUT.

---
 rtl/button_count_controller.sv | 158 +++++++++++++++
 tb/tb_button_count_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/button_count_controller.sv
// Three-button (UP/DOWN/CLEAR) controller for a shared count register.
// Does edge detection, CLEAR > UP > DOWN arbitration, hold-to-auto-repeat and wrap/saturate stepping.
module button_count_controller #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter bit          SATURATE      = 1'b0
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_btn_up,
  input  logic             i_btn_down,
  input  logic             i_btn_clear,
  output logic [WIDTH-1:0] o_out,
  output logic             o_step,
  output logic             o_repeating
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_REPEAT   = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_prev;        // {clear, up, down} levels from the previous edge
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_dir;         // 1 = up, 0 = down
  logic             w_dir_nxt;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_nxt;
  logic             r_step;
  logic             w_step_nxt;
  logic             r_repeating;

  logic             w_rise_up;
  logic             w_rise_down;
  logic             w_rise_clear;
  logic             w_dir_held;
  logic             w_any_btn;
  logic             w_any_dir_btn;
  logic             w_clear;
  logic             w_req;
  logic             w_req_up;
  logic             w_at_limit;
  logic             w_blocked;

  assign w_rise_clear  = i_btn_clear & ~r_prev[2];
  assign w_rise_up     = i_btn_up    & ~r_prev[1];
  assign w_rise_down   = i_btn_down  & ~r_prev[0];
  assign w_dir_held    = r_dir ? i_btn_up : i_btn_down;
  assign w_any_dir_btn = i_btn_up | i_btn_down;
  assign w_any_btn     = w_any_dir_btn | i_btn_clear;

  // Next-state and step-request decode; CLEAR pre-empts every state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_clear     = 1'b0;
    w_req       = 1'b0;
    w_req_up    = r_dir;
    if (w_rise_clear) begin
      w_clear     = 1'b1;
      w_cnt_nxt   = '0;
      w_state_nxt = w_any_dir_btn ? S_WAIT_REL : S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_rise_up || w_rise_down) begin
            w_req       = 1'b1;
            w_req_up    = w_rise_up;
            w_dir_nxt   = w_rise_up;
            w_cnt_nxt   = '0;
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD, S_REPEAT: begin
          // Release beats a coincident repeat step.
          if (!w_dir_held) begin
            w_cnt_nxt   = '0;
            w_state_nxt = w_any_btn ? S_WAIT_REL : S_IDLE;
          end else if (r_cnt == ((r_state == S_HOLD) ? DELAY_LAST : PERIOD_LAST)) begin
            w_req       = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_REPEAT;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_REL: begin
          if (!w_any_btn) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign w_at_limit = w_req_up ? (r_out == {WIDTH{1'b1}}) : (r_out == {WIDTH{1'b0}});
  assign w_blocked  = SATURATE && w_at_limit;

  // Count update; a saturated step leaves the count and strobe untouched.
  always_comb begin
    w_out_nxt  = r_out;
    w_step_nxt = 1'b0;
    if (w_clear) begin
      w_out_nxt  = '0;
      w_step_nxt = 1'b1;
    end else if (w_req && !w_blocked) begin
      w_out_nxt  = w_req_up ? (r_out + WIDTH'(1)) : (r_out - WIDTH'(1));
      w_step_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // prev resets high so a button held through reset must be re-pressed.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_prev      <= 3'b111;
      r_cnt       <= '0;
      r_dir       <= 1'b1;
      r_out       <= '0;
      r_step      <= 1'b0;
      r_repeating <= 1'b0;
    end else begin
      r_prev      <= {i_btn_clear, i_btn_up, i_btn_down};
      r_cnt       <= w_cnt_nxt;
      r_dir       <= w_dir_nxt;
      r_out       <= w_out_nxt;
      r_step      <= w_step_nxt;
      r_repeating <= (w_state_nxt == S_REPEAT);
    end
  end

  assign o_out       = r_out;
  assign o_step      = r_step;
  assign o_repeating = r_repeating;

endmodule

// File: tb/tb_button_count_controller.sv
// Directed bench for button_count_controller: a wrapping and a saturating
// instance share one stimulus stream and are checked against hand-derived values.
module tb_button_count_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up;
  logic       down;
  logic       clr;
  logic [7:0] out_w;
  logic [7:0] out_s;
  logic       step_w;
  logic       step_s;
  logic       rep_w;
  logic       rep_s;

  int n_cmp  = 0;
  int n_fail = 0;
  int steps_w = 0;
  int steps_s = 0;
  int reps_w  = 0;

  always #5 clk = ~clk;

  button_count_controller #(
    .WIDTH(8), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .SATURATE(1'b0)
  ) dut_w (
    .i_clock(clk), .i_reset_n(rst_n), .i_btn_up(up), .i_btn_down(down),
    .i_btn_clear(clr), .o_out(out_w), .o_step(step_w), .o_repeating(rep_w)
  );

  button_count_controller #(
    .WIDTH(8), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .SATURATE(1'b1)
  ) dut_s (
    .i_clock(clk), .i_reset_n(rst_n), .i_btn_up(up), .i_btn_down(down),
    .i_btn_clear(clr), .o_out(out_s), .o_step(step_s), .o_repeating(rep_s)
  );

  // Strobe/state activity counters sampled mid-cycle.
  always @(negedge clk) begin
    if (step_w === 1'b1) steps_w++;
    if (step_s === 1'b1) steps_s++;
    if (rep_w === 1'b1) reps_w++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input int o, input logic s, input logic r);
    check({tag, "/out_w"}, 32'(out_w), 32'(o));
    check({tag, "/step_w"}, 32'(step_w), 32'(s));
    check({tag, "/rep_w"}, 32'(rep_w), 32'(r));
  endtask

  task automatic check_s(input string tag, input int o, input logic s, input logic r);
    check({tag, "/out_s"}, 32'(out_s), 32'(o));
    check({tag, "/step_s"}, 32'(step_s), 32'(s));
    check({tag, "/rep_s"}, 32'(rep_s), 32'(r));
  endtask

  task automatic check_both(input string tag, input int o, input logic s, input logic r);
    check_w(tag, o, s, r);
    check_s(tag, o, s, r);
  endtask

  // Drive buttons, let one rising edge sample them, then settle.
  task automatic cyc(input logic u, input logic d, input logic c);
    up = u;
    down = d;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  // Hold UP for n edges: steps at 0, 4, then every 2; REPEATING from edge 4.
  task automatic hold_up(input string tag, input int n, input int start);
    int val;
    logic s;
    val = start;
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      s = (i == 0) || (i >= 4 && (i % 2) == 0);
      if (s) val++;
      check_both($sformatf("%s_e%0d", tag, i), val, s, i >= 4);
    end
  endtask

  initial begin
    int sw0;
    int ss0;
    int rw0;
    rst_n = 1'b0;
    up = 1'b0;
    down = 1'b0;
    clr = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check_both("reset", 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Three spaced single-cycle UP pulses
    sw0 = steps_w;
    ss0 = steps_s;
    rw0 = reps_w;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      check_both($sformatf("pulse_up%0d", i), i + 1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    check_both("pulses_done", 3, 1'b0, 1'b0);
    check("pulses_stepcnt_w", 32'(steps_w - sw0), 32'd3);
    check("pulses_stepcnt_s", 32'(steps_s - ss0), 32'd3);
    check("pulses_repcnt", 32'(reps_w - rw0), 32'd0);

    // Back down to zero, then underflow: wrap vs saturate
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    check_both("down_to_0", 0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check_w("underflow", 255, 1'b1, 1'b0);
    check_s("underflow", 0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_w("wrap_255_up", 0, 1'b1, 1'b0);
    check_s("sat_0_up", 1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Climb to the top: wrap lands on 254, saturate on 255
    for (int i = 0; i < 254; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    check_w("climb", 254, 1'b0, 1'b0);
    check_s("climb", 255, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_w("top_up1", 255, 1'b1, 1'b0);
    check_s("top_up1", 255, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_w("top_up2", 0, 1'b1, 1'b0);
    check_s("top_up2", 255, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // CLEAR, and CLEAR again at zero still strobes
    cyc(1'b0, 1'b0, 1'b1);
    check_both("clear", 0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check_both("clear_after", 0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check_both("clear_at0", 0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Auto-repeat: hold UP for 10 edges, release sampled on the 11th
    hold_up("hold", 10, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check_both("hold_release", 4, 1'b0, 1'b0);

    // Simultaneous UP+DOWN from 5
    cyc(1'b1, 1'b0, 1'b0);
    check_both("to5", 5, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check_both("updown", 6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      check_both($sformatf("down_held%0d", i), 6, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    check_both("all_released", 6, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check_both("down_repress", 5, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // CLEAR while in REPEAT
    hold_up("rpt", 7, 5);
    cyc(1'b1, 1'b0, 1'b1);
    check_both("clear_in_rpt", 0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      check_both($sformatf("up_after_clr%0d", i), 0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_both("clr_repress", 1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Reset mid-REPEAT with UP held through it
    hold_up("pre_rst", 13, 1);
    rst_n = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    check_both("rst_in_rpt", 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      check_both($sformatf("held_thru_rst%0d", i), 0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_both("rst_repress", 1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check_both("final", 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
